// File: rtl/key_debounce.sv
// Per-key 2-flop synchroniser and debounce FSM producing a clean level plus
// single-cycle press, release and long-press events (raw keys are active-low).
module key_debounce #(
  parameter int unsigned NUM_KEYS    = 2,
  parameter int unsigned DEB_CYCLES  = 1_000_000,
  parameter int unsigned LONG_CYCLES = 50_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] long_pulse
);

  localparam int unsigned CntW  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned LcntW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [CntW-1:0]  DebLast  = CntW'(DEB_CYCLES - 1);
  localparam logic [LcntW-1:0] LongLast = LcntW'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StPressF, StHeld, StRelF} state_e;

  logic [NUM_KEYS-1:0] sync1_q, sync2_q;
  logic [NUM_KEYS-1:0] k_s;

  // Synchroniser flops hold the raw (active-low) level, so reset means released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  assign k_s = ~sync2_q;

  for (genvar g = 0; g < int'(NUM_KEYS); g++) begin : g_key
    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [LcntW-1:0]  lcnt_q, lcnt_d;
    logic              long_done_q, long_done_d;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              rel_q, rel_d;
    logic              long_q, long_d;

    assign cnt_inc = cnt_q + CntW'(1);

    // The sample that leaves a stable state counts as the first of the window,
    // so acceptance compares the incremented count.
    always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      lcnt_d      = lcnt_q;
      long_done_d = long_done_q;
      level_d     = level_q;
      press_d     = 1'b0;
      rel_d       = 1'b0;
      long_d      = 1'b0;
      unique case (state_q)
        StIdle: begin
          if (k_s[g]) begin
            state_d = StPressF;
            cnt_d   = '0;
          end
        end
        StPressF: begin
          if (!k_s[g]) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == DebLast) begin
              state_d     = StHeld;
              level_d     = 1'b1;
              press_d     = 1'b1;
              lcnt_d      = '0;
              long_done_d = 1'b0;
            end
          end
        end
        StHeld: begin
          if (lcnt_q != LongLast) begin
            lcnt_d = lcnt_q + LcntW'(1);
          end else if (!long_done_q) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
          end
          if (!k_s[g]) begin
            state_d = StRelF;
            cnt_d   = '0;
          end
        end
        StRelF: begin
          if (k_s[g]) begin
            state_d = StHeld;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == DebLast) begin
              state_d = StIdle;
              level_d = 1'b0;
              rel_d   = 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q     <= StIdle;
        cnt_q       <= '0;
        lcnt_q      <= '0;
        long_done_q <= 1'b0;
        level_q     <= 1'b0;
        press_q     <= 1'b0;
        rel_q       <= 1'b0;
        long_q      <= 1'b0;
      end else begin
        state_q     <= state_d;
        cnt_q       <= cnt_d;
        lcnt_q      <= lcnt_d;
        long_done_q <= long_done_d;
        level_q     <= level_d;
        press_q     <= press_d;
        rel_q       <= rel_d;
        long_q      <= long_d;
      end
    end

    assign key_state[g]     = level_q;
    assign press_pulse[g]   = press_q;
    assign release_pulse[g] = rel_q;
    assign long_pulse[g]    = long_q;
  end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed scenarios plus random bouncing keys, all
// checked every cycle against a run-length model of the debounce rules.
module tb_key_debounce;
  localparam int NK   = 2;
  localparam int DEB  = 8;
  localparam int LONG = 40;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] key_n = '1;
  logic [NK-1:0] key_state, press_pulse, release_pulse, long_pulse;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: raw history, stable level, run of disagreeing samples, HELD edges.
  bit            h1[NK], h2[NK], stable[NK];
  int            run[NK], held[NK];
  logic [NK-1:0] exp_state = '0, exp_press = '0, exp_rel = '0, exp_long = '0;
  int            ev_press[NK], ev_rel[NK], ev_long[NK];
  int            dut_press[NK], dut_rel[NK], dut_long[NK];

  always #5 clk = ~clk;

  key_debounce #(
    .NUM_KEYS    (NK),
    .DEB_CYCLES  (DEB),
    .LONG_CYCLES (LONG)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_n         (key_n),
    .key_state     (key_state),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int i = 0; i < NK; i++) begin
      ev_press[i] = -1000; ev_rel[i] = -1000; ev_long[i] = -1000;
      dut_press[i] = 0; dut_rel[i] = 0; dut_long[i] = 0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < NK; i++) begin
          h1[i] = 1'b1; h2[i] = 1'b1; stable[i] = 1'b0; run[i] = 0; held[i] = 0;
        end
        exp_state = '0; exp_press = '0; exp_rel = '0; exp_long = '0;
      end else begin
        exp_press = '0; exp_rel = '0; exp_long = '0;
        for (int i = 0; i < NK; i++) begin
          if (!stable[i]) begin
            if (!h2[i]) begin
              run[i]++;
              if (run[i] == DEB) begin
                stable[i] = 1'b1; run[i] = 0; held[i] = 0;
                exp_press[i] = 1'b1; ev_press[i] = cyc + 1;
              end
            end else run[i] = 0;
          end else begin
            if (run[i] == 0) begin
              held[i]++;
              if (held[i] == LONG) begin
                exp_long[i] = 1'b1; ev_long[i] = cyc + 1;
              end
            end
            if (h2[i]) begin
              run[i]++;
              if (run[i] == DEB) begin
                stable[i] = 1'b0; run[i] = 0;
                exp_rel[i] = 1'b1; ev_rel[i] = cyc + 1;
              end
            end else run[i] = 0;
          end
          h2[i] = h1[i];
          h1[i] = key_n[i];
          exp_state[i] = stable[i];
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < NK; i++) begin
        check($sformatf("key_state[%0d]", i), key_state[i], exp_state[i]);
        check($sformatf("press_pulse[%0d]", i), press_pulse[i], exp_press[i]);
        check($sformatf("release_pulse[%0d]", i), release_pulse[i], exp_rel[i]);
        check($sformatf("long_pulse[%0d]", i), long_pulse[i], exp_long[i]);
        if (press_pulse[i] === 1'b1) dut_press[i]++;
        if (release_pulse[i] === 1'b1) dut_rel[i]++;
        if (long_pulse[i] === 1'b1) dut_long[i]++;
      end
    end
  end

  initial begin
    int t0, p0, r0, l0;
    int hold[NK];
    rst_n = 1'b0;
    key_n = 2'b11;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset: nothing happens.
    repeat (50) @(negedge clk);
    check("idle_press_count", dut_press[0] + dut_press[1], 0);
    check("idle_release_count", dut_rel[0] + dut_rel[1], 0);
    check("idle_long_count", dut_long[0] + dut_long[1], 0);

    // Clean press and release on key 0.
    t0 = cyc;
    key_n[0] = 1'b0;
    repeat (10) @(negedge clk);
    check("press_at_10", press_pulse, 2'b01);
    check("state_on_press", key_state[0], 1);
    check("model_press_latency", ev_press[0] - t0, 10);
    repeat (10) @(negedge clk);
    t0 = cyc;
    key_n[0] = 1'b1;
    repeat (10) @(negedge clk);
    check("release_at_10", release_pulse, 2'b01);
    check("state_on_release", key_state[0], 0);
    check("model_release_latency", ev_rel[0] - t0, 10);
    check("no_long_short_press", dut_long[0], 0);

    // Bouncing press: toggles every 3 cycles, ends low.
    repeat (15) @(negedge clk);
    p0 = dut_press[0];
    for (int k = 0; k <= 10; k++) begin
      key_n[0] = ~key_n[0];
      if (k < 10) repeat (3) @(negedge clk);
    end
    t0 = cyc;
    repeat (15) @(negedge clk);
    check("bounce_one_press", dut_press[0] - p0, 1);
    check("bounce_press_latency", ev_press[0] - t0, 10);
    key_n[0] = 1'b1;
    repeat (15) @(negedge clk);

    // Long hold on key 1, then a short release glitch.
    t0 = cyc;
    key_n[1] = 1'b0;
    repeat (100) @(negedge clk);
    check("long_press_latency", ev_press[1] - t0, 10);
    check("long_after_press", ev_long[1] - ev_press[1], 40);
    check("long_once", dut_long[1], 1);
    r0 = dut_rel[1];
    key_n[1] = 1'b1;
    repeat (4) @(negedge clk);
    key_n[1] = 1'b0;
    repeat (60) @(negedge clk);
    check("glitch_no_release", dut_rel[1] - r0, 0);
    check("glitch_no_second_long", dut_long[1], 1);
    check("glitch_still_held", key_state[1], 1);
    key_n[1] = 1'b1;
    repeat (15) @(negedge clk);

    // Simultaneous press, staggered releases.
    key_n = 2'b00;
    repeat (10) @(negedge clk);
    check("both_press", press_pulse, 2'b11);
    check("both_press_same_cycle", ev_press[0] - ev_press[1], 0);
    repeat (10) @(negedge clk);
    key_n[0] = 1'b1;
    repeat (5) @(negedge clk);
    key_n[1] = 1'b1;
    repeat (5) @(negedge clk);
    check("stagger_release0", release_pulse, 2'b01);
    repeat (5) @(negedge clk);
    check("stagger_release1", release_pulse, 2'b10);
    repeat (15) @(negedge clk);

    // Asynchronous reset while held; key still down afterwards.
    key_n[0] = 1'b0;
    repeat (20) @(negedge clk);
    p0 = dut_press[0];
    l0 = dut_long[0];
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_state", key_state, 2'b00);
    check("async_rst_pulses", {press_pulse, release_pulse, long_pulse}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    t0 = cyc;
    repeat (10) @(negedge clk);
    check("repress_after_reset", press_pulse, 2'b01);
    check("repress_count", dut_press[0] - p0, 1);
    check("repress_latency", ev_press[0] - t0, 10);
    check("repress_no_long", dut_long[0] - l0, 0);
    key_n[0] = 1'b1;
    repeat (15) @(negedge clk);

    // Random bouncing on both keys with occasional resets.
    p0 = dut_press[0] + dut_press[1];
    for (int i = 0; i < NK; i++) hold[i] = 0;
    for (int n = 0; n < 6000; n++) begin
      @(negedge clk);
      for (int i = 0; i < NK; i++) begin
        if (hold[i] == 0) begin
          key_n[i] = ~key_n[i];
          hold[i] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 10) : $urandom_range(8, 70);
        end else hold[i]--;
      end
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
    end
    check("random_saw_presses", (dut_press[0] + dut_press[1] - p0) > 0, 1);

    key_n = 2'b11;
    repeat (20) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
